tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-channel time-division demultiplexer that receives the serial stream produced by a rotating 4:1 selector (channel 0,1,2,3,0,…) and rebuilds the four parallel channels. Slot 0 of every frame is marked by a sync strobe. All four channels of a frame are captured into shadow registers and released together, with a one-cycle valid pulse. The block sits at the receive end of the 4:1 channel-select path and also checks that frame alignment is kept.

## Interface
- W, default 1: data width of each channel and of the serial input.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. Asynchronous and active-low.
- en  input  1  sample strobe. din and sync are valid only when en=1.
- sync  input  1  marks the current sample as slot 0 (channel 0). Ignored when en=0.
- din  input  W  serial channel data.
- err_clr  input  1  synchronous clear of sync_err.
- y0, y1, y2, y3  output  W each  registered channel outputs. They update only on frame completion.
- frame_valid  output  1  one-cycle pulse on the edge where y0..y3 update.
- slot  output  2  index of the next expected slot.
- locked  output  1  1 when the state is LOCK.
- sync_err  output  1  sticky alignment-error flag.

## Operation
- States:
  - HUNT (reset state): waiting for sync.
  - LOCK: capturing a frame.
- HUNT:
  - Samples with en=1 and sync=0 are discarded.
  - en=1 and sync=1: shadow0 <= din, slot <= 1, go to LOCK.
- LOCK, en=1, sync=0, slot in {1,2}: shadowN <= din, then slot increments.
- LOCK, en=1, sync=0, slot=3 (frame completes):
  - y0 <= shadow0, y1 <= shadow1, y2 <= shadow2, y3 <= din.
  - frame_valid <= 1, slot <= 0.
- LOCK, en=1, sync=1, slot=0 (normal frame start): shadow0 <= din, slot <= 1.
- LOCK, en=1, sync=1, slot in {1,2,3} (early sync):
  - sync_err <= 1.
  - The partial frame is discarded; y0..y3 are unchanged and there is no frame_valid.
  - Realign on this sample: shadow0 <= din, slot <= 1. Stay in LOCK.
- LOCK, en=1, sync=0, slot=0 (missing sync):
  - sync_err <= 1, the sample is discarded.
  - Go to HUNT with slot <= 0.
- en=0: no state, slot, shadow or output change. frame_valid is 0 on the next edge.
- sync_err stays set until err_clr=1. If err_clr and a new error occur on the same edge, the error wins (sync_err stays 1).
- Shadow registers are never visible at the outputs. y0..y3 always hold the last complete frame.

## Timing
- Reset values (asynchronous, applied while rst_n=0):
  - state = HUNT, slot = 0, locked = 0.
  - shadow0..3 = 0, y0..y3 = 0.
  - frame_valid = 0, sync_err = 0.
- Latency: y0..y3 and frame_valid update on the same clk edge that samples the slot-3 en.
  - They are visible in the following cycle.
  - frame_valid is high for exactly one cycle.
- Minimum frame is 4 consecutive en cycles. The fastest possible frame_valid rate is 1 in 4 cycles.
- Gaps (en=0) of any length inside a frame are legal and do not break alignment.
- Reset asserted mid-frame:
  - All state clears immediately.
  - The partial frame is lost, with no frame_valid.
  - The block needs a new sync after rst_n rises.
- Back-to-back frames: the slot-3 sample, then a sync on the next en, gives continuous operation with no error.

## Test plan
- Pattern 1,1,0,0 (W=1, en=1 each cycle, sync on slot 0), two frames:
  - frame_valid pulses after the 4th and 8th samples.
  - y0=1, y1=1, y2=0, y3=0.
  - sync_err=0, locked=1 after the first sync.
- Pre-sync garbage:
  - Stimulus: 3 samples with sync=0, then a frame 0,1,1,0.
  - Required: garbage is ignored; y0..y3 = 0,1,1,0 after one frame_valid; sync_err=0.
- Early sync:
  - Stimulus: sync at slot 0, 2 samples, then sync again, then 3 samples 1,0,1 after the new slot 0 = 1.
  - Required: sync_err=1. Exactly one frame_valid, holding the second frame. The first partial frame never appears on y.
- Missing sync:
  - Stimulus: after a good frame, a slot-0 sample with sync=0.
  - Required: sync_err=1, locked=0, y unchanged. Recovery on the next sync.
  - Then pulse err_clr; required: sync_err=0.
- en gaps and mid-frame reset:
  - Stimulus: a frame with en low for 5 cycles between slots 1 and 2.
  - Required: correct y, one frame_valid.
  - Stimulus: rst_n pulsed low at slot 2 of a following frame.
  - Required: all outputs are 0 immediately, with no frame_valid.

Source files
------------

// File: rtl/tdm_demux4.sv
// tdm_demux4: rebuilds four parallel channels from a rotating 4:1 TDM stream.
// Slot 0 is marked by a sync strobe. A frame is collected in shadow registers
// and released to y0..y3 together with a one-cycle frame_valid pulse.
// Alignment faults (early or missing sync) raise a sticky sync_err flag.
module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sync,
    input  logic [W-1:0] din,
    input  logic         err_clr,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic         frame_valid,
    output logic [1:0]   slot,
    output logic         locked,
    output logic         sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t         state_q,  state_d;
    logic [1:0]     slot_q,   slot_d;
    // Slot 3 needs no shadow register: it goes straight from din to y3.
    logic [W-1:0]   shadow0_q, shadow0_d;
    logic [W-1:0]   shadow1_q, shadow1_d;
    logic [W-1:0]   shadow2_q, shadow2_d;
    logic [W-1:0]   y0_q, y0_d;
    logic [W-1:0]   y1_q, y1_d;
    logic [W-1:0]   y2_q, y2_d;
    logic [W-1:0]   y3_q, y3_d;
    logic           frameValid_q, frameValid_d;
    logic           syncErr_q, syncErr_d;
    logic           errSet;

    // Next-state logic: slot tracking, frame capture and alignment checking.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        shadow0_d    = shadow0_q;
        shadow1_d    = shadow1_q;
        shadow2_d    = shadow2_q;
        y0_d         = y0_q;
        y1_d         = y1_q;
        y2_d         = y2_q;
        y3_d         = y3_q;
        frameValid_d = 1'b0;
        errSet       = 1'b0;

        if (en) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow0_d = din;
                        slot_d    = 2'd1;
                        state_d   = LOCK;
                    end
                end
                LOCK: begin
                    if (sync) begin
                        // A sync anywhere except slot 0 discards the partial
                        // frame and realigns on this sample.
                        if (slot_q != 2'd0) begin
                            errSet = 1'b1;
                        end
                        shadow0_d = din;
                        slot_d    = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd0: begin
                                errSet  = 1'b1;
                                slot_d  = 2'd0;
                                state_d = HUNT;
                            end
                            2'd1: begin
                                shadow1_d = din;
                                slot_d    = 2'd2;
                            end
                            2'd2: begin
                                shadow2_d = din;
                                slot_d    = 2'd3;
                            end
                            2'd3: begin
                                y0_d         = shadow0_q;
                                y1_d         = shadow1_q;
                                y2_d         = shadow2_q;
                                y3_d         = din;
                                frameValid_d = 1'b1;
                                slot_d       = 2'd0;
                            end
                            default: begin
                                slot_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end

        // A new error on the same edge as a clear keeps the flag set.
        if (errSet) begin
            syncErr_d = 1'b1;
        end else if (err_clr) begin
            syncErr_d = 1'b0;
        end else begin
            syncErr_d = syncErr_q;
        end
    end

    // State, shadow and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= 2'd0;
            shadow0_q    <= '0;
            shadow1_q    <= '0;
            shadow2_q    <= '0;
            y0_q         <= '0;
            y1_q         <= '0;
            y2_q         <= '0;
            y3_q         <= '0;
            frameValid_q <= 1'b0;
            syncErr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shadow0_q    <= shadow0_d;
            shadow1_q    <= shadow1_d;
            shadow2_q    <= shadow2_d;
            y0_q         <= y0_d;
            y1_q         <= y1_d;
            y2_q         <= y2_d;
            y3_q         <= y3_d;
            frameValid_q <= frameValid_d;
            syncErr_q    <= syncErr_d;
        end
    end

    assign y0          = y0_q;
    assign y1          = y1_q;
    assign y2          = y2_q;
    assign y3          = y3_q;
    assign frame_valid = frameValid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCK);
    assign sync_err    = syncErr_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: table-driven bench for tdm_demux4 with a frame scoreboard.
// Expected frames are queued when their slot-3 sample is driven and popped
// when frame_valid is seen; y0..y3 must otherwise hold the last frame.
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         sync;
    logic [W-1:0] din;
    logic         err_clr;
    logic [W-1:0] y0, y1, y2, y3;
    logic         frame_valid;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;

    typedef struct {
        logic         en;
        logic         sync;
        logic [W-1:0] din;
        logic         errClr;
        logic         expValid;
        logic [15:0]  expY;
        logic         expLocked;
        logic [1:0]   expSlot;
        logic         expErr;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] expQ[$];
    logic [15:0] lastY;
    int          vectorCount;
    int          failCount;

    tdm_demux4 #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync        (sync),
        .din         (din),
        .err_clr     (err_clr),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic addVec(input logic e, input logic s, input logic [W-1:0] d,
                          input logic ec, input logic ev, input logic [15:0] ey,
                          input logic el, input logic [1:0] es, input logic ee);
        vec_t v;
        v.en = e; v.sync = s; v.din = d; v.errClr = ec;
        v.expValid = ev; v.expY = ey; v.expLocked = el; v.expSlot = es; v.expErr = ee;
        vecs.push_back(v);
    endtask

    task automatic checkEq(input string name, input int idx,
                           input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Compares DUT outputs sampled just after the edge against the vector.
    task automatic checkOutput(input vec_t v, input int idx);
        if (frame_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL scoreboard (vector %0d): got frame_valid=1, expected no frame", idx);
            end else begin
                lastY = expQ.pop_front();
            end
        end
        checkEq("frame_valid", idx, {31'd0, frame_valid}, {31'd0, v.expValid});
        checkEq("locked",      idx, {31'd0, locked},      {31'd0, v.expLocked});
        checkEq("slot",        idx, {30'd0, slot},        {30'd0, v.expSlot});
        checkEq("sync_err",    idx, {31'd0, sync_err},    {31'd0, v.expErr});
        checkEq("y0..y3",      idx, {16'd0, y0, y1, y2, y3}, {16'd0, lastY});
    endtask

    // Drives one vector away from the active edge and checks after the edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        en      = v.en;
        sync    = v.sync;
        din     = v.din;
        err_clr = v.errClr;
        if (v.expValid) expQ.push_back(v.expY);
        @(posedge clk);
        #1;
        vectorCount++;
        checkOutput(v, idx);
    endtask

    task automatic checkAllZero(input string name);
        vectorCount++;
        checkEq({name, " y0..y3"},     -1, {16'd0, y0, y1, y2, y3}, 32'd0);
        checkEq({name, " frame_valid"}, -1, {31'd0, frame_valid}, 32'd0);
        checkEq({name, " slot"},        -1, {30'd0, slot}, 32'd0);
        checkEq({name, " locked"},      -1, {31'd0, locked}, 32'd0);
        checkEq({name, " sync_err"},    -1, {31'd0, sync_err}, 32'd0);
    endtask

    task automatic runTable(input int first);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], first + i);
        end
        vecs.delete();
    endtask

    initial begin
        vectorCount = 0;
        failCount   = 0;
        lastY       = 16'h0000;
        rst_n   = 1'b0;
        en      = 1'b0;
        sync    = 1'b0;
        din     = '0;
        err_clr = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Pre-sync garbage, then frame 0,1,1,0.
        addVec(1, 0, 4'h5, 0, 0, 16'h0000, 0, 2'd0, 0);
        addVec(1, 0, 4'h6, 0, 0, 16'h0000, 0, 2'd0, 0);
        addVec(1, 0, 4'h7, 0, 0, 16'h0000, 0, 2'd0, 0);
        addVec(1, 1, 4'h0, 0, 0, 16'h0000, 1, 2'd1, 0);
        addVec(1, 0, 4'h1, 0, 0, 16'h0000, 1, 2'd2, 0);
        addVec(1, 0, 4'h1, 0, 0, 16'h0000, 1, 2'd3, 0);
        addVec(1, 0, 4'h0, 0, 1, 16'h0110, 1, 2'd0, 0);
        // Two back-to-back frames 1,1,0,0.
        for (int f = 0; f < 2; f++) begin
            addVec(1, 1, 4'h1, 0, 0, 16'h0000, 1, 2'd1, 0);
            addVec(1, 0, 4'h1, 0, 0, 16'h0000, 1, 2'd2, 0);
            addVec(1, 0, 4'h0, 0, 0, 16'h0000, 1, 2'd3, 0);
            addVec(1, 0, 4'h0, 0, 1, 16'h1100, 1, 2'd0, 0);
        end
        // Sync while en=0 is ignored; frame with a 5-cycle gap.
        addVec(0, 1, 4'hF, 0, 0, 16'h0000, 1, 2'd0, 0);
        addVec(1, 1, 4'h9, 0, 0, 16'h0000, 1, 2'd1, 0);
        addVec(1, 0, 4'hA, 0, 0, 16'h0000, 1, 2'd2, 0);
        for (int g = 0; g < 5; g++) begin
            addVec(0, 0, 4'h3, 0, 0, 16'h0000, 1, 2'd2, 0);
        end
        addVec(1, 0, 4'hB, 0, 0, 16'h0000, 1, 2'd3, 0);
        addVec(1, 0, 4'hC, 0, 1, 16'h9ABC, 1, 2'd0, 0);
        addVec(0, 0, 4'h0, 0, 0, 16'h0000, 1, 2'd0, 0);
        // Early sync at slot 2: partial frame 3,4 dropped, frame 1,1,0,1 kept.
        addVec(1, 1, 4'h3, 0, 0, 16'h0000, 1, 2'd1, 0);
        addVec(1, 0, 4'h4, 0, 0, 16'h0000, 1, 2'd2, 0);
        addVec(1, 1, 4'h1, 0, 0, 16'h0000, 1, 2'd1, 1);
        addVec(1, 0, 4'h1, 0, 0, 16'h0000, 1, 2'd2, 1);
        addVec(1, 0, 4'h0, 0, 0, 16'h0000, 1, 2'd3, 1);
        addVec(1, 0, 4'h1, 0, 1, 16'h1101, 1, 2'd0, 1);
        addVec(0, 0, 4'h0, 1, 0, 16'h0000, 1, 2'd0, 0);
        // Missing sync together with err_clr: error wins, back to HUNT.
        addVec(1, 0, 4'h7, 1, 0, 16'h0000, 0, 2'd0, 1);
        addVec(1, 0, 4'h2, 0, 0, 16'h0000, 0, 2'd0, 1);
        addVec(1, 1, 4'h8, 0, 0, 16'h0000, 1, 2'd1, 1);
        addVec(1, 0, 4'h9, 0, 0, 16'h0000, 1, 2'd2, 1);
        addVec(1, 0, 4'hA, 0, 0, 16'h0000, 1, 2'd3, 1);
        addVec(1, 0, 4'hB, 0, 1, 16'h89AB, 1, 2'd0, 1);
        addVec(0, 0, 4'h0, 1, 0, 16'h0000, 1, 2'd0, 0);
        // Start of a frame that reset will cut off at slot 2.
        addVec(1, 1, 4'h1, 0, 0, 16'h0000, 1, 2'd1, 0);
        addVec(1, 0, 4'h2, 0, 0, 16'h0000, 1, 2'd2, 0);
        runTable(0);

        // Mid-frame asynchronous reset clears everything immediately.
        @(negedge clk);
        en    = 1'b1;
        sync  = 1'b0;
        din   = 4'h3;
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset");
        lastY = 16'h0000;
        @(posedge clk);
        #1;
        checkAllZero("held reset");
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;

        // After reset a new sync is required.
        addVec(1, 0, 4'h5, 0, 0, 16'h0000, 0, 2'd0, 0);
        addVec(1, 1, 4'h4, 0, 0, 16'h0000, 1, 2'd1, 0);
        addVec(1, 0, 4'h3, 0, 0, 16'h0000, 1, 2'd2, 0);
        addVec(1, 0, 4'h2, 0, 0, 16'h0000, 1, 2'd3, 0);
        addVec(1, 0, 4'h1, 0, 1, 16'h4321, 1, 2'd0, 0);
        addVec(0, 0, 4'h0, 0, 0, 16'h0000, 1, 2'd0, 0);
        runTable(100);

        vectorCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard drain: got %0d frames pending, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
